// File: rtl/grad_combine_pkg.sv
// Shared definitions for the gradient pipeline: pixel/image sizes,
// the saturating 8-bit helper and the tagged output pixel payload.
package grad_combine_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned IMG_W = 220;
  localparam int unsigned IMG_H = 220;
  localparam int unsigned POS_W = 8;

  // Clamp a (PIX_W+1)-bit sum to PIX_W bits.
  function automatic logic [PIX_W-1:0] sat8(input logic [PIX_W:0] sum);
    return sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
  endfunction

  // One tagged output pixel as seen by the frame writer.
  typedef struct packed {
    logic [PIX_W-1:0] mag;
    logic             is_edge;
    logic             valid;
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
    logic             eol;
    logic             eof;
  } pix_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, reset (async active-low)
//   wr_en/wr_data : push; accepted when not full, or when a pop happens the same cycle
//   rd_en         : pop the head word (ignored when empty)
//   rd_data       : head word, combinational from the storage array
//   empty/full    : occupancy flags derived from the registered count
module sync_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic do_rd_c;
  logic do_wr_c;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_rd_c = rd_en && !empty;
  assign do_wr_c = wr_en && (!full || do_rd_c);

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy state; pointers wrap naturally at 2**AW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd_c) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr_c, do_rd_c})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/grad_combine.sv
// Gradient-combine stage: aligns the |gx| and |gy| streams in FIFOs,
// produces mag = sat255(gx+gy), an edge bit, and position/line/frame tags.
//   clk, reset (async active-low)
//   gx_in/gx_valid, gy_in/gy_valid : free-running upstream pixel streams
//   mag_out, edge_out, valid       : registered result, valid is a one-cycle strobe
//   col, row, eol, eof             : position of the pixel on mag_out
//   overflow                       : sticky, a push hit a full FIFO
module grad_combine
  import grad_combine_pkg::*;
#(
  parameter int unsigned      W       = IMG_W,
  parameter int unsigned      H       = IMG_H,
  parameter int unsigned      FIFO_AW = 9,
  parameter logic [PIX_W-1:0] THRESH  = 8'd64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] gx_in,
  input  logic             gx_valid,
  input  logic [PIX_W-1:0] gy_in,
  input  logic             gy_valid,
  output logic [PIX_W-1:0] mag_out,
  output logic             edge_out,
  output logic             valid,
  output logic [POS_W-1:0] col,
  output logic [POS_W-1:0] row,
  output logic             eol,
  output logic             eof,
  output logic             overflow
);

  localparam logic [POS_W-1:0] LAST_COL = POS_W'(W - 1);
  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(H - 1);

  logic [PIX_W-1:0] gx_head;
  logic [PIX_W-1:0] gy_head;
  logic             gx_empty;
  logic             gy_empty;
  logic             gx_full;
  logic             gy_full;

  logic             pop_c;
  logic [PIX_W:0]   sum_c;
  logic [PIX_W-1:0] mag_c;
  logic             last_col_c;
  logic             last_row_c;
  logic             drop_c;

  logic [POS_W-1:0] col_cnt;
  logic [POS_W-1:0] row_cnt;
  pix_tag_t         out_q;
  logic             overflow_q;

  sync_fifo #(.DW(PIX_W), .AW(FIFO_AW)) u_gx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (gx_valid),
    .wr_data (gx_in),
    .rd_en   (pop_c),
    .rd_data (gx_head),
    .empty   (gx_empty),
    .full    (gx_full)
  );

  sync_fifo #(.DW(PIX_W), .AW(FIFO_AW)) u_gy_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (gy_valid),
    .wr_data (gy_in),
    .rd_en   (pop_c),
    .rd_data (gy_head),
    .empty   (gy_empty),
    .full    (gy_full)
  );

  // Pair the two heads as soon as both streams have a word waiting.
  assign pop_c      = !gx_empty && !gy_empty;
  assign sum_c      = {1'b0, gx_head} + {1'b0, gy_head};
  assign mag_c      = sat8(sum_c);
  assign last_col_c = (col_cnt == LAST_COL);
  assign last_row_c = (row_cnt == LAST_ROW);

  // A push is lost only when its FIFO is full and nothing drains it this cycle.
  assign drop_c = !pop_c && ((gx_valid && gx_full) || (gy_valid && gy_full));

  // Position of the next pixel to be popped; wraps per line and per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pop_c) begin
      if (last_col_c) begin
        col_cnt <= '0;
        row_cnt <= last_row_c ? '0 : row_cnt + POS_W'(1);
      end else begin
        col_cnt <= col_cnt + POS_W'(1);
      end
    end
  end

  // Output register: data and position update on pop, strobes last one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else if (pop_c) begin
      out_q.mag     <= mag_c;
      out_q.is_edge <= (mag_c >= THRESH);
      out_q.valid   <= 1'b1;
      out_q.col     <= col_cnt;
      out_q.row     <= row_cnt;
      out_q.eol     <= last_col_c;
      out_q.eof     <= last_col_c && last_row_c;
    end else begin
      out_q.valid <= 1'b0;
      out_q.eol   <= 1'b0;
      out_q.eof   <= 1'b0;
    end
  end

  // Sticky overflow, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop_c) begin
      overflow_q <= 1'b1;
    end
  end

  assign mag_out  = out_q.mag;
  assign edge_out = out_q.is_edge;
  assign valid    = out_q.valid;
  assign col      = out_q.col;
  assign row      = out_q.row;
  assign eol      = out_q.eol;
  assign eof      = out_q.eof;
  assign overflow = overflow_q;

endmodule
